// File: rtl/panel_ctrl_fsm_pkg.sv
// Shared definitions for the appliance panel controller: state encoding and
// the order in which simultaneous panel events are resolved.
package panel_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Lower value wins when several events land in the same clock.
  localparam int unsigned PRIO_ERR  = 32'd0;
  localparam int unsigned PRIO_OFF  = 32'd1;
  localparam int unsigned PRIO_OPEN = 32'd2;
  localparam int unsigned PRIO_ON   = 32'd3;

endpackage

// File: rtl/panel_ctrl_fsm_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, never restarted
// by control events so tick phase is independent of the FSM.
module panel_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             tick_r;

  // next prescaler count
  always_comb begin
    cnt_s = cnt_r;
    if (cnt_r == CNT_W'(TICK_DIV - 1)) begin
      cnt_s = {CNT_W{1'b0}};
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // count register; tick is registered so it is high exactly while cnt_r is at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= (cnt_s == CNT_W'(TICK_DIV - 1));
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/panel_ctrl_fsm.sv
// Panel control: edge-detects the debounced buttons, runs the OFF/RUN/PAUSE/FAULT
// state machine, drives LEDs and buzzer, and accumulates RUN seconds.
module panel_ctrl_fsm
  import panel_ctrl_fsm_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int BEEP_TICKS = 20,
  parameter int SEC_TICKS  = 100,
  parameter int TIME_W     = 8
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              db_on,
  input  logic              db_off,
  input  logic              db_err,
  input  logic              db_open,
  input  logic              db_buzzer,
  output logic [1:0]        state,
  output logic              led_run,
  output logic              led_open,
  output logic              led_fault,
  output logic              buzzer_out,
  output logic [TIME_W-1:0] run_time
);

  localparam int BEEP_W = $clog2(BEEP_TICKS + 1);
  localparam int FCNT_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam int SEC_W  = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;

  logic              tick_s;
  logic              prev_on_r, prev_off_r, prev_err_r, prev_open_r, prev_buzzer_r;
  logic              edge_on_s, edge_off_s, edge_err_s, edge_buzzer_s;
  state_e            state_r, state_s;
  logic              open_beep_s, beep_trig_s;
  logic [BEEP_W-1:0] beep_r, beep_s;
  logic              tog_r, tog_s;
  logic [FCNT_W-1:0] fcnt_r, fcnt_s;
  logic [SEC_W-1:0]  sec_r, sec_s;
  logic [TIME_W-1:0] run_time_r, run_time_s;
  logic              led_run_r, led_fault_r, buzzer_r;

  panel_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk_50MHz),
    .reset (reset),
    .tick  (tick_s)
  );

  assign edge_on_s     = db_on & ~prev_on_r;
  assign edge_off_s    = db_off & ~prev_off_r;
  assign edge_err_s    = db_err & ~prev_err_r;
  assign edge_buzzer_s = db_buzzer & ~prev_buzzer_r;

  // next state, resolving same-cycle events as err > off > open > on
  always_comb begin
    state_s     = state_r;
    open_beep_s = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (edge_err_s) begin
          state_s = ST_FAULT;
        end else if (edge_off_s) begin
          state_s = ST_OFF;
        end else if (edge_on_s && db_open) begin
          open_beep_s = 1'b1;
        end else if (edge_on_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_RUN: begin
        if (edge_err_s) begin
          state_s = ST_FAULT;
        end else if (edge_off_s) begin
          state_s = ST_OFF;
        end else if (db_open) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (edge_err_s) begin
          state_s = ST_FAULT;
        end else if (edge_off_s) begin
          state_s = ST_OFF;
        end else if (!db_open) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_FAULT: begin
        if (edge_off_s) begin
          state_s = ST_OFF;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_OFF;
      end
    endcase
  end

  // beep counter, fault chirp and run-time counters
  always_comb begin
    beep_s      = beep_r;
    tog_s       = tog_r;
    fcnt_s      = fcnt_r;
    sec_s       = sec_r;
    run_time_s  = run_time_r;
    beep_trig_s = (edge_buzzer_s && (state_r != ST_FAULT)) || open_beep_s;

    // a load beats a coincident tick so a retrigger always gives a full beep
    if ((state_r == ST_FAULT) && (state_s != ST_FAULT)) begin
      beep_s = {BEEP_W{1'b0}};
    end else if (beep_trig_s) begin
      beep_s = BEEP_W'(BEEP_TICKS);
    end else if (tick_s && (beep_r != {BEEP_W{1'b0}})) begin
      beep_s = beep_r - BEEP_W'(1);
    end else begin
      beep_s = beep_r;
    end

    if ((state_s == ST_FAULT) && (state_r != ST_FAULT)) begin
      tog_s  = 1'b1;
      fcnt_s = {FCNT_W{1'b0}};
    end else if (state_s != ST_FAULT) begin
      tog_s  = 1'b0;
      fcnt_s = {FCNT_W{1'b0}};
    end else if (tick_s) begin
      if (fcnt_r == FCNT_W'(BEEP_TICKS - 1)) begin
        fcnt_s = {FCNT_W{1'b0}};
        tog_s  = ~tog_r;
      end else begin
        fcnt_s = fcnt_r + FCNT_W'(1);
      end
    end else begin
      tog_s  = tog_r;
      fcnt_s = fcnt_r;
    end

    if (state_s == ST_OFF) begin
      sec_s      = {SEC_W{1'b0}};
      run_time_s = {TIME_W{1'b0}};
    end else if ((state_r == ST_RUN) && tick_s) begin
      if (sec_r == SEC_W'(SEC_TICKS - 1)) begin
        sec_s = {SEC_W{1'b0}};
        if (run_time_r != {TIME_W{1'b1}}) begin
          run_time_s = run_time_r + TIME_W'(1);
        end else begin
          run_time_s = run_time_r;
        end
      end else begin
        sec_s = sec_r + SEC_W'(1);
      end
    end else begin
      sec_s      = sec_r;
      run_time_s = run_time_r;
    end
  end

  // state, history and counter registers; outputs registered from next-state values
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_r       <= ST_OFF;
      prev_on_r     <= 1'b0;
      prev_off_r    <= 1'b0;
      prev_err_r    <= 1'b0;
      prev_open_r   <= 1'b0;
      prev_buzzer_r <= 1'b0;
      beep_r        <= {BEEP_W{1'b0}};
      tog_r         <= 1'b0;
      fcnt_r        <= {FCNT_W{1'b0}};
      sec_r         <= {SEC_W{1'b0}};
      run_time_r    <= {TIME_W{1'b0}};
      led_run_r     <= 1'b0;
      led_fault_r   <= 1'b0;
      buzzer_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      prev_on_r     <= db_on;
      prev_off_r    <= db_off;
      prev_err_r    <= db_err;
      prev_open_r   <= db_open;
      prev_buzzer_r <= db_buzzer;
      beep_r        <= beep_s;
      tog_r         <= tog_s;
      fcnt_r        <= fcnt_s;
      sec_r         <= sec_s;
      run_time_r    <= run_time_s;
      led_run_r     <= (state_s == ST_RUN);
      led_fault_r   <= (state_s == ST_FAULT);
      buzzer_r      <= (state_s == ST_FAULT) ? tog_s : (beep_s != {BEEP_W{1'b0}});
    end
  end

  assign state      = state_r;
  assign led_run    = led_run_r;
  assign led_fault  = led_fault_r;
  assign led_open   = db_open;
  assign buzzer_out = buzzer_r;
  assign run_time   = run_time_r;

endmodule
